// File: rtl/cla_pkg.sv
// Shared constants and state encoding for the nibble-serial cla adder.
package cla_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/cla_seq_adder_if.sv
// Requester/consumer handshake bundle for cla_seq_adder.
interface cla_seq_adder_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, s, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, s, cout, busy
  );

endinterface

// File: rtl/cla.sv
// 4-bit carry-lookahead slice; the nibble datapath shared across all steps.
module cla
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic               c1, c2, c3;

  assign g = a & b;
  assign p = a ^ b;

  // Fully expanded lookahead terms, no ripple between bits.
  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a single cla slice,
// LSB nibble first, carry held in a register between steps.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  cla_seq_adder_if.slave bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned STEP_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSLICE - 1);

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cout_q, cout_d;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;

  cla u_cla (
    .a    (opa_q[SLICE_W-1:0]),
    .b    (opb_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    s_d     = s_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opa_d   = bus.a;
          opb_d   = bus.b;
          carry_d = bus.cin;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = slice_cout;
        opa_d   = opa_q >> SLICE_W;
        opb_d   = opob_shift(opb_q);
        sum_d   = (sum_q >> SLICE_W) | (WIDTH'(slice_s) << (WIDTH - SLICE_W));
        if (step_q == LAST_STEP) begin
          // Result becomes visible only here; s never shows partial sums.
          s_d     = sum_d;
          cout_d  = slice_cout;
          state_d = DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  function automatic logic [WIDTH-1:0] opob_shift(input logic [WIDTH-1:0] v);
    return v >> SLICE_W;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Randomised self-checking bench for cla_seq_adder against a plain a+b+cin model.
module tb_cla_seq_adder;

  localparam int W = 16;
  localparam int LAT = W / 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [W-1:0] prev_s;
  logic         prev_cout;

  cla_seq_adder_if #(.WIDTH(W)) bus ();

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Present operands for one edge; caller has already seen in_ready high.
  task automatic start_op(input logic [W-1:0] a, b, input logic cin);
    bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Edges from accept until out_valid; flags any movement of s/cout before then.
  task automatic wait_done(output int cyc, output logic moved);
    cyc = 0; moved = 1'b0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.out_valid === 1'b1) break;
      if (bus.s !== prev_s || bus.cout !== prev_cout) moved = 1'b1;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.s !== '0) begin n_fail++; $display("FAIL reset_s got %h want 0000", bus.s); end
    n_checks++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", bus.cout); end
    prev_s = '0; prev_cout = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vc [4];
    logic [W:0]   e;
    int           cyc;
    logic         moved;
    va = '{16'h0001, 16'h0FFF, 16'hFFFF, 16'hFFFF};
    vb = '{16'h0002, 16'h0001, 16'hFFFF, 16'h0000};
    vc = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      e = model(va[i], vb[i], vc[i]);
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready got %b want 1", i, bus.in_ready); end
      start_op(va[i], vb[i], vc[i]);
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL dir%0d_busy got %b want 1", i, bus.busy); end
      wait_done(cyc, moved);
      n_checks++; if (cyc != LAT) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, cyc, LAT); end
      n_checks++; if (moved !== 1'b0) begin n_fail++; $display("FAIL dir%0d_s_stable_in_run got %b want 0", i, moved); end
      n_checks++; if (bus.s !== e[W-1:0]) begin n_fail++; $display("FAIL dir%0d_s got %h want %h", i, bus.s, e[W-1:0]); end
      n_checks++; if (bus.cout !== e[W]) begin n_fail++; $display("FAIL dir%0d_cout got %b want %b", i, bus.cout, e[W]); end
      prev_s = e[W-1:0]; prev_cout = e[W];
      consume();
      n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL dir%0d_release got ov=%b ir=%b want ov=0 ir=1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  // Back-to-back random transactions: each accept follows the previous release directly.
  task automatic test_random();
    logic [W-1:0] a, b;
    logic         c;
    logic [W:0]   e;
    int           cyc;
    logic         moved;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      e = model(a, b, c);
      start_op(a, b, c);
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      wait_done(cyc, moved);
      n_checks++; if (cyc != LAT || moved !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_timing got lat=%0d moved=%b want lat=%0d moved=0", i, cyc, moved, LAT);
      end
      n_checks++; if ({bus.cout, bus.s} !== e) begin
        n_fail++; $display("FAIL rnd%0d_sum %h+%h+%b got %b_%h want %b_%h", i, a, b, c, bus.cout, bus.s, e[W], e[W-1:0]);
      end
      prev_s = e[W-1:0]; prev_cout = e[W];
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, na, nb;
    logic [W:0]   e, ne;
    int           cyc;
    logic         moved;
    a = W'($urandom); b = W'($urandom);
    na = W'($urandom); nb = W'($urandom);
    e = model(a, b, 1'b0);
    ne = model(na, nb, 1'b1);
    start_op(a, b, 1'b0);
    wait_done(cyc, moved);
    for (int k = 0; k < 3; k++) begin
      bus.a = na; bus.b = nb; bus.cin = 1'b1; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp%0d_handshake got ov=%b ir=%b want ov=1 ir=0", k, bus.out_valid, bus.in_ready);
      end
      n_checks++; if ({bus.cout, bus.s} !== e) begin
        n_fail++; $display("FAIL bp%0d_hold got %b_%h want %b_%h", k, bus.cout, bus.s, e[W], e[W-1:0]);
      end
    end
    consume();
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    prev_s = e[W-1:0]; prev_cout = e[W];
    wait_done(cyc, moved);
    n_checks++; if (cyc != LAT || moved !== 1'b0) begin
      n_fail++; $display("FAIL bp_next_timing got lat=%0d moved=%b want lat=%0d moved=0", cyc, moved, LAT);
    end
    n_checks++; if ({bus.cout, bus.s} !== ne) begin
      n_fail++; $display("FAIL bp_next_sum got %b_%h want %b_%h", bus.cout, bus.s, ne[W], ne[W-1:0]);
    end
    prev_s = ne[W-1:0]; prev_cout = ne[W];
    consume();
  endtask

  task automatic test_operand_change();
    logic [W:0] e;
    int         cyc;
    logic       moved;
    e = model(16'h1234, 16'h4321, 1'b0);
    start_op(16'h1234, 16'h4321, 1'b0);
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1'b1;
    wait_done(cyc, moved);
    n_checks++; if ({bus.cout, bus.s} !== e) begin
      n_fail++; $display("FAIL opchg_sum got %b_%h want %b_%h", bus.cout, bus.s, e[W], e[W-1:0]);
    end
    prev_s = e[W-1:0]; prev_cout = e[W];
    consume();
  endtask

  task automatic test_reset_mid();
    logic [W:0] e;
    int         cyc;
    logic       moved;
    start_op(16'hABCD, 16'h1357, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_immediate got busy=%b ov=%b want busy=0 ov=0", bus.busy, bus.out_valid);
    end
    n_checks++; if (bus.s !== '0 || bus.cout !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outputs got %b_%h want 0_0000", bus.cout, bus.s);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_no_pulse got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready);
    end
    prev_s = '0; prev_cout = 1'b0;
    e = model(16'h8000, 16'h8000, 1'b0);
    start_op(16'h8000, 16'h8000, 1'b0);
    wait_done(cyc, moved);
    n_checks++; if (cyc != LAT) begin n_fail++; $display("FAIL rstmid_latency got %0d want %0d", cyc, LAT); end
    n_checks++; if ({bus.cout, bus.s} !== e) begin
      n_fail++; $display("FAIL rstmid_sum got %b_%h want %b_%h", bus.cout, bus.s, e[W], e[W-1:0]);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_operand_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
